ay_bus_master: RTL and testbench

//  CPU-side initiator for an external AY-3-8910/YM2149 on GPIO pins. Turns port 14 (data) / port 15
//  (address) CPU accesses into timed BDIR/BC1/BC2 bus cycles (latch-address, write-data, read-data).

---
 rtl/ay_bus_pkg.sv | 34 +++
 rtl/ay_phase_timer.sv | 26 ++
 rtl/ay_bus_master.sv | 150 +++++++++++++++
 tb/tb_ay_bus_master.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ay_bus_pkg.sv
// Shared types and constants for the AY-3-8910/YM2149 bus master: phase/kind enums, {bdir,bc1} codes, port numbers.
// Pure declarations; no timing or backpressure of its own.
package ay_bus_pkg;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;
   typedef enum logic [1:0] {K_ADDR, K_WR, K_RD} kind_t;

   localparam logic [1:0] CODE_IDLE = 2'b00;
   localparam logic [1:0] CODE_RD   = 2'b01;
   localparam logic [1:0] CODE_WR   = 2'b10;
   localparam logic [1:0] CODE_ADDR = 2'b11;

   localparam int PORT_DATA = 14;
   localparam int PORT_ADDR = 15;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   function automatic logic [1:0] strobe_code(input kind_t k);
      case (k)
         K_ADDR:  return CODE_ADDR;
         K_WR:    return CODE_WR;
         K_RD:    return CODE_RD;
         default: return CODE_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/ay_phase_timer.sv
// Loadable phase down-counter: load sets (len-1), counts to 0 and stops there; zero flags the last phase cycle.
// Latency: load visible the cycle after the load edge; no backpressure.
module ay_phase_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/ay_bus_master.sv
// CPU port 14/15 accesses to timed AY BDIR/BC1/BC2 bus cycles; busy the cycle after acceptance, requests while busy dropped and flagged in overrun.
// Optional AY_BUS_SHADOW_EN adds a 16x8 shadow so data reads of registers 0..13 skip the bus.
module ay_bus_master
   import ay_bus_pkg::*;
#(
   parameter int T_SU = 2,
   parameter int T_PW = 4,
   parameter int T_RD = 6,
   parameter int T_HO = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       address,
   input  logic [7:0] data,
   input  logic       wren,
   input  logic       rden,
   output logic [7:0] q,
   output logic       q_valid,
   output logic       busy,
   output logic       overrun,
   output logic       ay_bdir,
   output logic       ay_bc1,
   output logic       ay_bc2,
   output logic [7:0] ay_da_o,
   output logic       ay_da_oe,
   input  logic [7:0] ay_da_i
);

   localparam int TW = $clog2(max4(T_SU, T_PW, T_RD, T_HO)) + 1;
   localparam logic [TW-1:0] L_SU = TW'(T_SU - 1);
   localparam logic [TW-1:0] L_PW = TW'(T_PW - 1);
   localparam logic [TW-1:0] L_RD = TW'(T_RD - 1);
   localparam logic [TW-1:0] L_HO = TW'(T_HO - 1);

   state_t        state, state_nxt;
   kind_t         kind;
   logic [7:0]    cur_addr;
   logic [7:0]    da_o_r;
   logic [7:0]    da_i_q;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_zero;
   logic          accept;
   logic          shadow_hit;
   logic          start_bus;

   assign accept = (state == S_IDLE) && (wren || rden);

`ifdef AY_BUS_SHADOW_EN
   logic [7:0] shadow [16];

   assign shadow_hit = !wren && rden && !address && (cur_addr < 8'(PORT_DATA));

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) shadow[i] <= '0;
      end else if (accept && wren && !address && (cur_addr[7:4] == 4'h0)) begin
         shadow[cur_addr[3:0]] <= data;
      end
   end
`else
   assign shadow_hit = 1'b0;
`endif

   // Port-15 reads and shadow hits complete without a bus cycle.
   assign start_bus = accept && (wren || (!address && !shadow_hit));

   ay_phase_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      case (state)
         S_IDLE: if (start_bus) begin
            state_nxt = S_SETUP;
            tmr_load  = 1'b1;
            tmr_val   = L_SU;
         end
         S_SETUP: if (tmr_zero) begin
            state_nxt = S_STROBE;
            tmr_load  = 1'b1;
            tmr_val   = (kind == K_RD) ? L_RD : L_PW;
         end
         S_STROBE: if (tmr_zero) begin
            state_nxt = S_HOLD;
            tmr_load  = 1'b1;
            tmr_val   = L_HO;
         end
         S_HOLD: if (tmr_zero) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_addr <= '0;
         kind     <= K_ADDR;
         da_o_r   <= '0;
         da_i_q   <= '0;
         q        <= '0;
         q_valid  <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         da_i_q  <= ay_da_i;
         q_valid <= 1'b0;
         if ((state != S_IDLE) && (wren || rden))
            overrun <= 1'b1;
         if (accept) begin
            if (wren) begin
               kind   <= address ? K_ADDR : K_WR;
               da_o_r <= data;
               if (address) cur_addr <= data;
            end else if (address) begin
               q       <= cur_addr;
               q_valid <= 1'b1;
`ifdef AY_BUS_SHADOW_EN
            end else if (shadow_hit) begin
               q       <= shadow[cur_addr[3:0]];
               q_valid <= 1'b1;
`endif
            end else begin
               kind <= K_RD;
            end
         end
         if ((state == S_STROBE) && (kind == K_RD) && tmr_zero) begin
            q       <= da_i_q;
            q_valid <= 1'b1;
         end
      end
   end

   assign busy                = (state != S_IDLE);
   assign {ay_bdir, ay_bc1}   = (state == S_STROBE) ? strobe_code(kind) : CODE_IDLE;
   assign ay_bc2              = 1'b1;
   assign ay_da_o             = da_o_r;
   assign ay_da_oe            = busy && (kind != K_RD);

endmodule

// File: tb/tb_ay_bus_master.sv
// Bench for ay_bus_master: cycle model built from phase lengths and accept times, checked every cycle,
// plus directed scenarios with hand-computed counts and values.
module tb_ay_bus_master;

   localparam int T_SU = 2, T_PW = 4, T_RD = 6, T_HO = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       address = 1'b0;
   logic [7:0] data = '0;
   logic       wren = 1'b0;
   logic       rden = 1'b0;
   logic [7:0] ay_da_i = '0;
   logic [7:0] q, ay_da_o;
   logic       q_valid, busy, overrun, ay_bdir, ay_bc1, ay_bc2, ay_da_oe;

   ay_bus_master #(.T_SU(T_SU), .T_PW(T_PW), .T_RD(T_RD), .T_HO(T_HO)) dut (
      .clk(clk), .reset(reset), .address(address), .data(data), .wren(wren), .rden(rden),
      .q(q), .q_valid(q_valid), .busy(busy), .overrun(overrun),
      .ay_bdir(ay_bdir), .ay_bc1(ay_bc1), .ay_bc2(ay_bc2),
      .ay_da_o(ay_da_o), .ay_da_oe(ay_da_oe), .ay_da_i(ay_da_i)
   );

   always #5 clk = ~clk;

   // Model: kind 0 = address latch, 1 = data write, 2 = data read.
   int         cyc = 0;
   int         m_start = 1, m_end = 0, m_kind = 0, m_qv = -1;
   logic [7:0] m_dat = '0, m_q = '0, m_cur = '0, prev_dai = '0;
   logic       m_ovr = 1'b0;
   logic [7:0] m_shadow [16];

   always @(posedge clk) begin
      int  n;
      bit  was_busy;
      cyc = cyc + 1;
      n = cyc;
      if (reset) begin
         m_start = 1; m_end = 0; m_kind = 0; m_qv = -1;
         m_dat = '0; m_q = '0; m_cur = '0; m_ovr = 1'b0;
         for (int i = 0; i < 16; i++) m_shadow[i] = '0;
      end else begin
         was_busy = (n - 1 >= m_start) && (n - 1 <= m_end);
         if (was_busy && m_kind == 2 && (n - 1 == m_start + T_SU + T_RD - 1)) begin
            m_q = prev_dai;
            m_qv = n;
         end
         if (was_busy && (wren || rden)) begin
            m_ovr = 1'b1;
         end else if (!was_busy && wren) begin
            m_dat = data;
            m_kind = address ? 0 : 1;
            if (address) m_cur = data;
            else if (m_cur < 16) m_shadow[m_cur[3:0]] = data;
            m_start = n;
            m_end = n + T_SU + T_PW + T_HO - 1;
         end else if (!was_busy && rden) begin
            if (address) begin
               m_q = m_cur; m_qv = n;
`ifdef AY_BUS_SHADOW_EN
            end else if (m_cur < 14) begin
               m_q = m_shadow[m_cur[3:0]]; m_qv = n;
`endif
            end else begin
               m_kind = 2;
               m_start = n;
               m_end = n + T_SU + T_RD + T_HO - 1;
            end
         end
      end
      prev_dai = ay_da_i;
   end

   int    n_tests = 0, n_fail = 0;
   int    cnt_busy = 0, cnt_11 = 0, cnt_10 = 0, cnt_01 = 0, cnt_oe = 0, cnt_qv = 0;
   string lit_name = "";
   int    lit_act = 0, lit_exp = 0, lit_seq = 0, lit_seen = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      bit   bz, stb;
      int   k, ts;
      logic [1:0] ecode;
      if (cyc > 0) begin
         bz = (cyc >= m_start) && (cyc <= m_end);
         k  = cyc - m_start;
         ts = (m_kind == 2) ? T_RD : T_PW;
         stb = bz && (k >= T_SU) && (k < T_SU + ts);
         ecode = !stb ? 2'b00 : (m_kind == 0) ? 2'b11 : (m_kind == 1) ? 2'b10 : 2'b01;
         chk("busy", busy, bz);
         chk("bdir_bc1", {ay_bdir, ay_bc1}, ecode);
         chk("bc2", ay_bc2, 1);
         chk("da_oe", ay_da_oe, bz && m_kind != 2);
         if (bz && m_kind != 2) chk("da_o", ay_da_o, m_dat);
         chk("q", q, m_q);
         chk("q_valid", q_valid, cyc == m_qv);
         chk("overrun", overrun, m_ovr);
         if (busy) cnt_busy++;
         if ({ay_bdir, ay_bc1} == 2'b11) cnt_11++;
         if ({ay_bdir, ay_bc1} == 2'b10) cnt_10++;
         if ({ay_bdir, ay_bc1} == 2'b01) cnt_01++;
         if (ay_da_oe) cnt_oe++;
         if (q_valid) cnt_qv++;
      end
      if (lit_seq != lit_seen) begin
         chk(lit_name, lit_act, lit_exp);
         lit_seen = lit_seq;
      end
   end

   task automatic lit(input string nm, input int act, input int exp);
      lit_name = nm; lit_act = act; lit_exp = exp;
      lit_seq++;
      @(negedge clk);
      #1;
   endtask

   task automatic req(input logic w, input logic r, input logic a, input logic [7:0] d);
      wren = w; rden = r; address = a; data = d;
      @(posedge clk);
      #1;
      wren = 1'b0; rden = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(posedge clk);
         #1;
         if (!busy) done = 1'b1;
      end
      if (!done) lit("wait_idle_timeout", 1, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int b_busy, b_11, b_10, b_01, b_oe, b_qv;
   task automatic snap();
      b_busy = cnt_busy; b_11 = cnt_11; b_10 = cnt_10;
      b_01 = cnt_01; b_oe = cnt_oe; b_qv = cnt_qv;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      lit("reset_busy", busy, 0);
      lit("reset_pins", {ay_bdir, ay_bc1, ay_bc2, ay_da_oe}, 4'b0010);
      lit("reset_q", q, 0);

      // 1: latch address 07
      snap();
      req(1, 0, 1, 8'h07);
      wait_idle();
      lit("t1_strobe11", cnt_11 - b_11, 4);
      lit("t1_busy", cnt_busy - b_busy, 8);
      lit("t1_da_oe", cnt_oe - b_oe, 8);

      // 2: data write 38
      snap();
      req(1, 0, 0, 8'h38);
      wait_idle();
      lit("t2_strobe10", cnt_10 - b_10, 4);
      lit("t2_busy", cnt_busy - b_busy, 8);
      lit("t2_da_o", ay_da_o, 8'h38);

      // 3: data read of A5
      ay_da_i = 8'hA5;
      snap();
      req(0, 1, 0, 8'h00);
      wait_idle();
      ay_da_i = 8'h3C;
      idle(3);
      lit("t3_strobe01", cnt_01 - b_01, 6);
      lit("t3_busy", cnt_busy - b_busy, 10);
      lit("t3_da_oe", cnt_oe - b_oe, 0);
      lit("t3_qv", cnt_qv - b_qv, 1);
      lit("t3_q", q, 8'hA5);

      // 4: latch 0B then read address port
      req(1, 0, 1, 8'h0B);
      wait_idle();
      snap();
      req(0, 1, 1, 8'h00);
      idle(3);
      lit("t4_q", q, 8'h0B);
      lit("t4_qv", cnt_qv - b_qv, 1);
      lit("t4_nobus", (cnt_busy - b_busy) + (cnt_01 - b_01) + (cnt_11 - b_11), 0);

      // 5: overrun, then wren+rden together
      snap();
      req(1, 0, 0, 8'h11);
      req(1, 0, 0, 8'h22);
      wait_idle();
      lit("t5_overrun", overrun, 1);
      lit("t5_first_len", cnt_10 - b_10, 4);
      snap();
      req(1, 1, 0, 8'h44);
      wait_idle();
      idle(2);
      lit("t5_wr_only", cnt_10 - b_10, 4);
      lit("t5_no_read", (cnt_01 - b_01) + (cnt_qv - b_qv), 0);
      lit("t5_da_o", ay_da_o, 8'h44);

      // 6: reset during strobe
      req(1, 0, 0, 8'h55);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (ay_bdir || ay_bc1) seen = 1'b1;
         end
         lit("t6_strobe_seen", seen, 1);
      end
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      lit("t6_pins", {ay_bdir, ay_bc1, ay_da_oe}, 0);
      lit("t6_busy", busy, 0);
      lit("t6_overrun", overrun, 0);

`ifdef AY_BUS_SHADOW_EN
      req(1, 0, 1, 8'h03);
      wait_idle();
      req(1, 0, 0, 8'h5A);
      wait_idle();
      snap();
      req(0, 1, 0, 8'h00);
      idle(3);
      lit("sh_q", q, 8'h5A);
      lit("sh_nobus", (cnt_busy - b_busy) + (cnt_01 - b_01), 0);
      lit("sh_qv", cnt_qv - b_qv, 1);
`endif

      idle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
